// File: rtl/rv32i_types_pkg.sv
// Shared types for the dispatch/issue front end: functional-unit select and
// register-specifier width.
package rv32i_types_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        FU_ARITH = 2'd0,
        FU_MUL   = 2'd1,
        FU_DIV   = 2'd2,
        FU_LS    = 2'd3
    } fu_sel_t;

endpackage

// File: rtl/reg_busy_table.sv
// Per-register busy bit and owning completion-buffer index. x0 is never
// tracked; flush clears every busy bit and a same-cycle set beats a clear.
module reg_busy_table import rv32i_types_pkg::*; #(
    parameter int NUM_ENTRY = 16,
    parameter int NUM_REGS  = 32,
    localparam int IW       = $clog2(NUM_ENTRY)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set_ena_i,
    input  logic [REG_AW-1:0] set_rd_i,
    input  logic [IW-1:0]     set_owner_i,
    input  logic              clr_ena_i,
    input  logic [REG_AW-1:0] clr_rd_i,
    input  logic [IW-1:0]     clr_index_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] rd_a_addr_i,
    input  logic [REG_AW-1:0] rd_b_addr_i,
    output logic              rd_a_busy_o,
    output logic              rd_b_busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [IW-1:0]       owner_q [NUM_REGS];
    logic [IW-1:0]       owner_d [NUM_REGS];
    logic                set_hit, clr_hit;

    assign set_hit = set_ena_i && (set_rd_i != '0) && (32'(set_rd_i) < NUM_REGS);

    // Only the current owner may release the register; older WAW writers are ignored.
    assign clr_hit = clr_ena_i && (clr_rd_i != '0) && (32'(clr_rd_i) < NUM_REGS)
                     && busy_q[clr_rd_i] && (owner_q[clr_rd_i] == clr_index_i);

    assign rd_a_busy_o = (32'(rd_a_addr_i) < NUM_REGS) ? busy_q[rd_a_addr_i] : 1'b0;
    assign rd_b_busy_o = (32'(rd_b_addr_i) < NUM_REGS) ? busy_q[rd_b_addr_i] : 1'b0;

    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (clr_hit) begin
                busy_d[clr_rd_i] = 1'b0;
            end
            if (set_hit) begin
                busy_d[set_rd_i]  = 1'b1;
                owner_d[set_rd_i] = set_owner_i;
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) begin
                owner_q[r] <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

endmodule

// File: rtl/dispatch_scoreboard.sv
// In-order dispatch: RAW check against the busy table, completion-buffer
// allocation at the current tail, and a single issue slot toward the units.
module dispatch_scoreboard import rv32i_types_pkg::*; #(
    parameter int NUM_ENTRY = 16,
    parameter int NUM_REGS  = 32,
    localparam int IW       = $clog2(NUM_ENTRY)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rs1_used,
    input  logic              dec_rs2_used,
    input  logic              dec_wen,
    input  logic [1:0]        dec_fu,
    input  logic [31:0]       dec_payload,
    input  logic              cb_full,
    input  logic [IW-1:0]     cb_cur_tail,
    output logic              alloc_ena,
    input  logic              commit_ena,
    input  logic [IW-1:0]     commit_index,
    input  logic [REG_AW-1:0] commit_rd,
    input  logic              commit_wen,
    input  logic              flush,
    input  logic [3:0]        fu_ready,
    output logic              issue_valid,
    output logic [1:0]        issue_fu,
    output logic [IW-1:0]     issue_index,
    output logic [REG_AW-1:0] issue_rs1,
    output logic [REG_AW-1:0] issue_rs2,
    output logic [REG_AW-1:0] issue_rd,
    output logic              issue_wen,
    output logic [31:0]       issue_payload
);

    logic              issue_valid_q, issue_valid_d;
    fu_sel_t           issue_fu_q, issue_fu_d;
    logic [IW-1:0]     issue_index_q, issue_index_d;
    logic [REG_AW-1:0] issue_rs1_q, issue_rs1_d;
    logic [REG_AW-1:0] issue_rs2_q, issue_rs2_d;
    logic [REG_AW-1:0] issue_rd_q, issue_rd_d;
    logic              issue_wen_q, issue_wen_d;
    logic [31:0]       issue_payload_q, issue_payload_d;

    logic rs1_busy, rs2_busy, stall, fire, accept;

    reg_busy_table #(
        .NUM_ENTRY (NUM_ENTRY),
        .NUM_REGS  (NUM_REGS)
    ) u_busy (
        .CLK         (CLK),
        .nRST        (nRST),
        .set_ena_i   (accept & dec_wen),
        .set_rd_i    (dec_rd),
        .set_owner_i (cb_cur_tail),
        .clr_ena_i   (commit_ena & commit_wen),
        .clr_rd_i    (commit_rd),
        .clr_index_i (commit_index),
        .flush_i     (flush),
        .rd_a_addr_i (dec_rs1),
        .rd_b_addr_i (dec_rs2),
        .rd_a_busy_o (rs1_busy),
        .rd_b_busy_o (rs2_busy)
    );

    // Registered busy state only: a committing producer unblocks its consumer next cycle.
    assign stall     = (dec_rs1_used & rs1_busy) | (dec_rs2_used & rs2_busy);
    assign fire      = issue_valid_q & fu_ready[issue_fu_q];
    assign dec_ready = ~flush & ~cb_full & ~stall & (~issue_valid_q | fire);
    assign accept    = dec_valid & dec_ready;
    assign alloc_ena = accept;

    always_comb begin
        issue_valid_d   = issue_valid_q;
        issue_fu_d      = issue_fu_q;
        issue_index_d   = issue_index_q;
        issue_rs1_d     = issue_rs1_q;
        issue_rs2_d     = issue_rs2_q;
        issue_rd_d      = issue_rd_q;
        issue_wen_d     = issue_wen_q;
        issue_payload_d = issue_payload_q;
        if (flush) begin
            issue_valid_d = 1'b0;
        end else if (accept) begin
            issue_valid_d   = 1'b1;
            issue_fu_d      = fu_sel_t'(dec_fu);
            issue_index_d   = cb_cur_tail;
            issue_rs1_d     = dec_rs1;
            issue_rs2_d     = dec_rs2;
            issue_rd_d      = dec_rd;
            issue_wen_d     = dec_wen;
            issue_payload_d = dec_payload;
        end else if (fire) begin
            issue_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            issue_valid_q   <= 1'b0;
            issue_fu_q      <= FU_ARITH;
            issue_index_q   <= '0;
            issue_rs1_q     <= '0;
            issue_rs2_q     <= '0;
            issue_rd_q      <= '0;
            issue_wen_q     <= 1'b0;
            issue_payload_q <= '0;
        end else begin
            issue_valid_q   <= issue_valid_d;
            issue_fu_q      <= issue_fu_d;
            issue_index_q   <= issue_index_d;
            issue_rs1_q     <= issue_rs1_d;
            issue_rs2_q     <= issue_rs2_d;
            issue_rd_q      <= issue_rd_d;
            issue_wen_q     <= issue_wen_d;
            issue_payload_q <= issue_payload_d;
        end
    end

    assign issue_valid   = issue_valid_q;
    assign issue_fu      = issue_fu_q;
    assign issue_index   = issue_index_q;
    assign issue_rs1     = issue_rs1_q;
    assign issue_rs2     = issue_rs2_q;
    assign issue_rd      = issue_rd_q;
    assign issue_wen     = issue_wen_q;
    assign issue_payload = issue_payload_q;

endmodule
